// File: rtl/sysbus_arbiter_pkg.sv
// Shared types and reset constants for the instruction/data system-bus arbiter.
package sysbus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } arb_state_t;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } arb_owner_t;

  localparam arb_state_t  StateRst     = StIdle;
  localparam arb_owner_t  OwnerRst     = OwnerI;
  localparam arb_owner_t  LastOwnerRst = OwnerD;
  localparam logic [31:0] WordRst      = 32'h0;

  // On a tie the side that did not win last time gets the bus.
  function automatic arb_owner_t pick_owner(logic i_req, logic d_req, arb_owner_t last_owner);
    if (i_req && d_req) begin
      return (last_owner == OwnerD) ? OwnerI : OwnerD;
    end
    return i_req ? OwnerI : OwnerD;
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Watchdog for a granted system-bus transfer; expires after TIMEOUT counted cycles.
module bus_timeout #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] count_q;

  // Fires during the TIMEOUT-th enabled cycle after a clear.
  assign expired = count_en && (count_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single registered system bus.
// Optional transfer watchdog enabled by defining SYSBUS_ARB_TIMEOUT_EN.
module sysbus_arbiter
  import sysbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("TIMEOUT must be nonzero");
  end

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  arb_owner_t  last_owner_q, last_owner_d;
  arb_owner_t  grant;
  logic        grant_valid;
  logic        armed_q;
  logic        timeout_hit;

  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

`ifdef SYSBUS_ARB_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_busy;

  assign tmo_clear = grant_valid;
  assign tmo_busy  = (state_q == StBusy);

  bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmo_clear),
    .count_en (tmo_busy),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Holds off the first grant until the second edge after reset release.
  assign grant_valid = (state_q == StIdle) && armed_q && (i_req || d_req);
  assign grant       = pick_owner(i_req, d_req, last_owner_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d      = grant;
          last_owner_d = grant;
          m_req_d      = 1'b1;
          state_d      = StBusy;
          if (grant == OwnerI) begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = WordRst;
            m_wstrb_d = 4'h0;
          end else begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
          end
        end
      end
      StBusy: begin
        if (m_ack) begin
          rdata_d = m_rdata;
          err_d   = m_err;
          m_req_d = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = WordRst;
          err_d   = 1'b1;
          m_req_d = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        rdata_d = WordRst;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StateRst;
      owner_q      <= OwnerRst;
      last_owner_q <= LastOwnerRst;
      armed_q      <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= WordRst;
      m_wdata_q    <= WordRst;
      m_wstrb_q    <= 4'h0;
      rdata_q      <= WordRst;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      armed_q      <= 1'b1;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

  // Response outputs are gated so they read zero whenever no ack is high.
  assign i_ack     = (state_q == StResp) && (owner_q == OwnerI);
  assign d_ack     = (state_q == StResp) && (owner_q == OwnerD);
  assign rsp_rdata = (state_q == StResp) ? rdata_q : WordRst;
  assign rsp_err   = (state_q == StResp) && err_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed self-checking bench for sysbus_arbiter.
module tb_sysbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;

  int tests = 0;
  int fails = 0;

  sysbus_arbiter #(
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ack     (d_ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .m_err     (m_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " i_ack"}, {31'd0, i_ack}, 32'd0);
    chk({tag, " d_ack"}, {31'd0, d_ack}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  // Both acks high in the same cycle is never legal.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      tests++;
      assert (!(i_ack && d_ack)) else begin
        fails++;
        $error("FAIL dual_ack: got i_ack=%0b d_ack=%0b, expected at most one", i_ack, d_ack);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    m_err   = 1'b0;

    // Reset state
    step();
    step();
    chk("rst m_req", {31'd0, m_req}, 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk_idle_outputs("rst");

    // Single fetch; first grant lands on the second edge after release
    rst    = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h8000_0000;
    step();
    chk("fetch early grant", {31'd0, m_req}, 32'd0);
    step();
    chk("fetch m_req", {31'd0, m_req}, 32'd1);
    chk("fetch m_addr", m_addr, 32'h8000_0000);
    chk("fetch m_we", {31'd0, m_we}, 32'd0);
    chk("fetch m_wstrb", {28'd0, m_wstrb}, 32'd0);
    chk("fetch m_wdata", m_wdata, 32'd0);
    step();
    step();
    m_ack   = 1'b1;
    m_rdata = 32'h0000_0013;
    step();
    chk("fetch i_ack", {31'd0, i_ack}, 32'd1);
    chk("fetch d_ack", {31'd0, d_ack}, 32'd0);
    chk("fetch rsp_rdata", rsp_rdata, 32'h0000_0013);
    chk("fetch m_req low", {31'd0, m_req}, 32'd0);
    i_req = 1'b0;
    m_ack = 1'b0;
    step();
    chk_idle_outputs("fetch after");

    // Stray m_ack in IDLE
    m_ack = 1'b1;
    step();
    step();
    chk("stray m_req", {31'd0, m_req}, 32'd0);
    chk_idle_outputs("stray");
    m_ack = 1'b0;

    // Data write with bus error; mid-transfer field changes are ignored
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h8000_1000;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'hF;
    step();
    chk("wr m_req", {31'd0, m_req}, 32'd1);
    chk("wr m_we", {31'd0, m_we}, 32'd1);
    chk("wr m_addr", m_addr, 32'h8000_1000);
    chk("wr m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("wr m_wstrb", {28'd0, m_wstrb}, 32'hF);
    d_addr  = 32'h1234_5678;
    d_wdata = 32'h0;
    step();
    chk("wr m_addr held", m_addr, 32'h8000_1000);
    chk("wr m_wdata held", m_wdata, 32'hDEAD_BEEF);
    m_ack   = 1'b1;
    m_err   = 1'b1;
    m_rdata = 32'h0000_1234;
    step();
    chk("wr d_ack", {31'd0, d_ack}, 32'd1);
    chk("wr i_ack", {31'd0, i_ack}, 32'd0);
    chk("wr rsp_err", {31'd0, rsp_err}, 32'd1);
    d_req = 1'b0;
    d_we  = 1'b0;
    m_ack = 1'b0;
    m_err = 1'b0;
    step();
    chk_idle_outputs("wr after");

    // Repeated ties from reset: I, D, then alternating
    rst = 1'b0;
    step();
    i_req  = 1'b1;
    d_req  = 1'b1;
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    step();
    chk("tie rst m_req", {31'd0, m_req}, 32'd0);
    rst = 1'b1;
    step();
    chk("tie early grant", {31'd0, m_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("tie%0d m_req", i), {31'd0, m_req}, 32'd1);
      chk($sformatf("tie%0d m_addr", i), m_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      m_ack   = 1'b1;
      m_rdata = 32'(i + 32'hA0);
      step();
      chk($sformatf("tie%0d i_ack", i), {31'd0, i_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d d_ack", i), {31'd0, d_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("tie%0d rsp_rdata", i), rsp_rdata, 32'(i + 32'hA0));
      m_ack = 1'b0;
      step();
      chk($sformatf("tie%0d idle m_req", i), {31'd0, m_req}, 32'd0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // Reset in the middle of a transfer
    i_req  = 1'b1;
    i_addr = 32'h0000_0300;
    step();
    chk("abort m_req before", {31'd0, m_req}, 32'd1);
    #2;
    rst   = 1'b0;
    m_ack = 1'b1;
    #1;
    chk("abort m_req immediate", {31'd0, m_req}, 32'd0);
    chk_idle_outputs("abort immediate");
    step();
    chk_idle_outputs("abort held");
    rst    = 1'b1;
    m_ack  = 1'b0;
    i_addr = 32'h0000_0304;
    step();
    chk("abort early grant", {31'd0, m_req}, 32'd0);
    chk_idle_outputs("abort release");
    step();
    chk("post-abort m_req", {31'd0, m_req}, 32'd1);
    chk("post-abort m_addr", m_addr, 32'h0000_0304);
    m_ack   = 1'b1;
    m_rdata = 32'h0000_0055;
    step();
    chk("post-abort i_ack", {31'd0, i_ack}, 32'd1);
    chk("post-abort rsp_rdata", rsp_rdata, 32'h0000_0055);
    i_req = 1'b0;
    m_ack = 1'b0;
    step();

    // Transfer that is never acked
    d_req   = 1'b1;
    d_addr  = 32'h0000_0400;
    m_rdata = 32'hFFFF_FFFF;
    step();
    chk("noack m_req", {31'd0, m_req}, 32'd1);
`ifdef SYSBUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("tmo busy%0d m_req", i + 2), {31'd0, m_req}, 32'd1);
      chk($sformatf("tmo busy%0d d_ack", i + 2), {31'd0, d_ack}, 32'd0);
    end
    step();
    chk("tmo m_req low", {31'd0, m_req}, 32'd0);
    chk("tmo d_ack", {31'd0, d_ack}, 32'd1);
    chk("tmo rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("tmo rsp_rdata", rsp_rdata, 32'd0);
    d_req = 1'b0;
    step();
    chk_idle_outputs("tmo after");
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("hold%0d m_req", i), {31'd0, m_req}, 32'd1);
    end
    chk("hold d_ack", {31'd0, d_ack}, 32'd0);
    m_ack   = 1'b1;
    m_rdata = 32'h0000_0077;
    step();
    chk("hold d_ack late", {31'd0, d_ack}, 32'd1);
    chk("hold rsp_rdata", rsp_rdata, 32'h0000_0077);
    d_req = 1'b0;
    m_ack = 1'b0;
    step();
    chk_idle_outputs("hold after");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
